pe_conv_mac: RTL
================

# pe_conv_mac

Clocked, parametrised processing element for the mesh convolution network. It accepts addressed packets over a valid/ready link, holds a row of signed filter weights, and accumulates dot products over a programmable number of data packets. Each completed partial sum goes out as a new addressed packet through an output FIFO. It succeeds the fixed 33-bit, three-lane PE and generalises lane count, data width, address width, kernel length and output buffering. It adds address checking, drop accounting and optional ReLU.

## Interface
- ADDR_W, 2: bits per mesh coordinate (X or Y).
- LANES, 3: signed operands per packet.
- DATA_W, 8: bits per operand.
- ACC_W, 24: accumulator width; must be ≤ LANES*DATA_W.
- KLEN, 3: data packets per output result; must be ≥ 1.
- OUT_DEPTH, 4: output FIFO entries; must be ≥ 2.
- PE_X, 0 / PE_Y, 2: own mesh address.
- DST_X, 3 / DST_Y, 3: result destination address.
- Derived: PKT_W = 1 + 4*ADDR_W + LANES*DATA_W (33 at defaults).
- Packet layout, MSB first: type (1 = weights, 0 = data), src_x, src_y, dst_x, dst_y, payload. Lane 0 occupies the payload LSBs.
- Ports:
  - clk  in  1: sole clock, rising edge.
  - rst_n  in  1: asynchronous, active-low reset.
  - in_valid  in  1: input packet valid.
  - in_ready  out  1: input can be accepted.
  - in_pkt  in  PKT_W: input packet.
  - out_valid  out  1: FIFO head valid.
  - out_ready  in  1: downstream accepts the head.
  - out_pkt  out  PKT_W: FIFO head packet.
  - err_drop  out  1: one-cycle pulse when a packet is dropped.
  - drop_cnt  out  8: count of dropped packets; saturates at 255.

## Operation
- A packet is accepted on a rising edge with in_valid && in_ready.
- in_ready = rst_n && (FIFO count < OUT_DEPTH). It depends only on registered state.
- Address check: if {dst_x, dst_y} ≠ {PE_X, PE_Y}, the packet is dropped. err_drop pulses and drop_cnt increments. No other state changes.
- Weight packet: load LANES weights from the payload and set wvalid = 1. Clear acc and cnt, which abandons any partial sum.
- Data packet with wvalid = 0: dropped, same as a misrouted packet.
- Data packet with wvalid = 1:
  - dot = Σ sign-extended lane[i] × weight[i].
  - sum = acc + dot, modulo 2^ACC_W (two's-complement wrap, no saturation).
  - If cnt < KLEN-1: acc ← sum and cnt ← cnt+1.
  - If cnt = KLEN-1: push the result packet, then clear acc and cnt to 0.
- Result packet: type 0, src = {PE_X, PE_Y}, dst = {DST_X, DST_Y}. Payload = sum sign-extended to LANES*DATA_W, with the ReLU option applied.
- Weights persist across results until the next weight packet or reset.
- Output FIFO: circular buffer with registered head. Push and pop in the same cycle are allowed whenever not empty. Pointers wrap at OUT_DEPTH.

## Timing
- Reset values: in_ready 0 while rst_n is low, then 1. All of the following reset to 0: out_valid, out_pkt, err_drop, drop_cnt, acc, cnt, weights, wvalid, FIFO pointers.
- Asserting rst_n mid-accumulation or mid-drain discards all state immediately, including queued results.
- Latency: result push happens at the accept edge of the KLEN-th data packet. out_valid is high in the following cycle.
- err_drop is high for exactly the cycle after the dropping edge.
- out_pkt is stable while out_valid && !out_ready.
- Throughput: one packet per cycle while the FIFO is not full.
- Full FIFO: in_ready drops, so no accept and no push. A pop on that edge raises in_ready in the next cycle.

## Configuration
- PE_RELU_EN defined: a negative result sum produces payload 0. Non-negative sums pass unchanged.
- PE_RELU_EN undefined: the sign-extended raw sum is emitted. ReLU logic is absent.

## Test plan
All scenarios use default parameters.
- Basic dot product:
  - Stimulus: weights (1,1,1), then data (1,2,3), (4,5,6), (7,8,9).
  - Response: one out_pkt = {0, 0,2, 3,3, 24'h00002D}, out_valid one cycle after the third accept.
- Misroute:
  - Stimulus: data with dst (1,1).
  - Response: err_drop pulses once, drop_cnt = 1, no output, cnt unchanged.
  - Stimulus: data before any weight packet.
  - Response: dropped, drop_cnt = 2.
- Sign and ReLU:
  - Stimulus: weights (8'hFF, 0, 0), then three data packets with lane0 = 5.
  - Response: payload 24'hFFFFF1 without PE_RELU_EN; 24'h000000 with it.
- Backpressure:
  - Stimulus: out_ready = 0, then 15 data packets (five results).
  - Response: in_ready falls after the fourth result is queued. The 13th packet stalls. Raising out_ready drains results in order and accepts the remainder.
- Reload and reset:
  - Stimulus: weights (1,1,1), two data packets, then weights (2,2,2), then three data (1,1,1).
  - Response: a single result, payload 24'h000012.
  - Stimulus: drop rst_n mid-sequence.
  - Response: out_valid 0 and drop_cnt 0 immediately.

Source files
------------

// File: rtl/pe_conv_mac.sv
// Mesh convolution PE: addressed weight/data packets in, KLEN-deep dot-product accumulation, results out via FIFO.
// Optional ReLU on the emitted sum is enabled by defining PE_RELU_EN.
module pe_conv_mac #(
  parameter int ADDR_W    = 2,
  parameter int LANES     = 3,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int KLEN      = 3,
  parameter int OUT_DEPTH = 4,
  parameter int PE_X      = 0,
  parameter int PE_Y      = 2,
  parameter int DST_X     = 3,
  parameter int DST_Y     = 3,
  localparam int PKT_W    = 1 + 4*ADDR_W + LANES*DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic             err_drop,
  output logic [7:0]       drop_cnt
);
  localparam int PAY_W  = LANES*DATA_W;
  localparam int CNT_W  = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FCNT_W = $clog2(OUT_DEPTH + 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic logic [PAY_W-1:0] shape_result(input logic signed [ACC_W-1:0] s);
`ifdef PE_RELU_EN
    if (s < 0) return '0;
`endif
    return PAY_W'(s);
  endfunction

  logic signed [DATA_W-1:0] w_q [LANES];
  logic signed [DATA_W-1:0] w_d [LANES];
  logic                     wvalid_q, wvalid_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_drop_q, err_drop_d;
  logic [7:0]               drop_cnt_q, drop_cnt_d;
  logic [PKT_W-1:0]         mem_q [OUT_DEPTH];
  logic [PKT_W-1:0]         mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]        fcnt_q, fcnt_d;

  logic                      pkt_type, addr_ok, accept, drop, wload, dload, push, pop;
  logic signed [DATA_W-1:0]  lane;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   dot, sum;
  logic [PKT_W-1:0]          res_pkt;
  logic                      unused_src;

  assign unused_src = ^in_pkt[PKT_W-2 -: 2*ADDR_W];
  assign pkt_type   = in_pkt[PKT_W-1];
  assign addr_ok    = (in_pkt[PAY_W+ADDR_W +: ADDR_W] == ADDR_W'(PE_X)) &&
                      (in_pkt[PAY_W +: ADDR_W] == ADDR_W'(PE_Y));

  assign in_ready  = rst_n && (fcnt_q < FCNT_W'(OUT_DEPTH));
  assign out_valid = (fcnt_q != '0);
  assign out_pkt   = mem_q[rd_ptr_q];
  assign err_drop  = err_drop_q;
  assign drop_cnt  = drop_cnt_q;

  // Packet classification: misrouted packets and data before weights are both drops.
  assign accept = in_valid && in_ready;
  assign drop   = accept && (!addr_ok || (!pkt_type && !wvalid_q));
  assign wload  = accept && addr_ok && pkt_type;
  assign dload  = accept && addr_ok && !pkt_type && wvalid_q;
  assign push   = dload && (cnt_q == CNT_W'(KLEN-1));
  assign pop    = out_valid && out_ready;

  always_comb begin
    lane = '0;
    prod = '0;
    dot  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = signed'(in_pkt[i*DATA_W +: DATA_W]);
      prod = lane * w_q[i];
      dot  = dot + ACC_W'(prod);
    end
    sum     = acc_q + dot;
    res_pkt = {1'b0, ADDR_W'(PE_X), ADDR_W'(PE_Y), ADDR_W'(DST_X), ADDR_W'(DST_Y),
               shape_result(sum)};
  end

  always_comb begin
    w_d        = w_q;
    wvalid_d   = wvalid_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_drop_d = drop;
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    if (wload) begin
      for (int i = 0; i < LANES; i++) w_d[i] = signed'(in_pkt[i*DATA_W +: DATA_W]);
      wvalid_d = 1'b1;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (dload) begin
      acc_d = push ? '0 : sum;
      cnt_d = push ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Output FIFO: a push can only happen on an accept, which already guarantees space.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = res_pkt;
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) w_q[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wvalid_q   <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_drop_q <= 1'b0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      w_q        <= w_d;
      mem_q      <= mem_d;
      wvalid_q   <= wvalid_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_drop_q <= err_drop_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end
endmodule
